// File: rtl/mux81_scan_ctrl.sv
// Scan sequencer for an 8:1 mux: steps sel 0..7, captures y_in into a word.
// Optional continuous scanning when MUX_SCAN_CONT_EN is defined (adds cont).
module mux81_scan_ctrl #(
   parameter int SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       y_in,
`ifdef MUX_SCAN_CONT_EN
   input  logic       cont,
`endif
   output logic [2:0] sel,
   output logic       busy,
   output logic [7:0] data_out,
   output logic       valid
);

   typedef enum logic {IDLE, SCAN} state_t;

   localparam logic [3:0] CNT_MAX = 4'(SETTLE - 1);

   state_t     state, state_d;
   logic [2:0] sel_d;
   logic [3:0] cnt, cnt_d;
   logic [7:0] word, word_d;
   logic [7:0] data_d;
   logic       valid_d;
   logic       repeat_scan;

`ifdef MUX_SCAN_CONT_EN
   assign repeat_scan = cont;
`else
   assign repeat_scan = 1'b0;
`endif

   assign busy = (state == SCAN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         sel      <= 3'd0;
         cnt      <= 4'd0;
         word     <= 8'h00;
         data_out <= 8'h00;
         valid    <= 1'b0;
      end else begin
         state    <= state_d;
         sel      <= sel_d;
         cnt      <= cnt_d;
         word     <= word_d;
         data_out <= data_d;
         valid    <= valid_d;
      end
   end

   always_comb begin
      state_d = state;
      sel_d   = sel;
      cnt_d   = cnt;
      word_d  = word;
      data_d  = data_out;
      valid_d = 1'b0;
      unique case (state)
         IDLE: begin
            sel_d = 3'd0;
            cnt_d = 4'd0;
            if (start) state_d = SCAN;
         end
         SCAN: begin
            if (cnt < CNT_MAX) begin
               cnt_d = cnt + 4'd1;
            end else begin
               cnt_d       = 4'd0;
               word_d[sel] = y_in;
               if (sel != 3'd7) begin
                  sel_d = sel + 3'd1;
               end else begin
                  // word_d already holds bit 7 from this edge
                  data_d  = word_d;
                  valid_d = 1'b1;
                  sel_d   = 3'd0;
                  if (!repeat_scan) state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
